tune_sequencer: RTL

Note-table scheduler that drives the tune player's tone generator inside the user project. Firmware loads a table of {duration, period} entries over a simple write port. The sequencer then steps through the table at a programmable tempo. It hands each note to the tone generator with a valid/ready handshake and gates the generator for rests and end-of-tune.

---
 rtl/tune_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tune_sequencer.sv
// tune_sequencer: note-table scheduler for the tune player's tone generator.
//
// Firmware fills a table of {dur, period} entries through the cfg_* write
// port. On start the sequencer walks the table from address 0, offering each
// note to the tone generator with a valid/ready handshake and then timing it
// for dur tempo ticks of (tempo_div+1) clocks each.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_we/addr/wdata   table write port, entry = {dur, period}
//   start, stop         begin playback at address 0 / abort playback
//   loop_en             restart at address 0 on end marker or table wrap
//   tempo_div           clocks per tempo tick minus one
//   tone_period/en      current note period and tone gate
//   tone_valid/ready    note handshake with the tone generator
//   busy, done          playback active / one-cycle natural-end pulse
//   cur_addr            address of the entry being played
module tune_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int PERIOD_W = 12,
  parameter int DUR_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [DUR_W+PERIOD_W-1:0] cfg_wdata,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [15:0]               tempo_div,
  output logic [PERIOD_W-1:0]       tone_period,
  output logic                      tone_en,
  output logic                      tone_valid,
  input  logic                      tone_ready,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         cur_addr
);

  localparam int ENT_W = DUR_W + PERIOD_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_PLAY} state_t;

  state_t              state_q, state_d;
  logic [ENT_W-1:0]    mem [0:DEPTH-1];
  logic [ENT_W-1:0]    ent_q, ent_d;
  logic                fetched_q, fetched_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                en_q, en_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         tick_q, tick_d;
  logic [DUR_W-1:0]    dur_q, dur_d;

  logic [DUR_W-1:0]    ent_dur;
  logic [PERIOD_W-1:0] ent_per;

  assign ent_dur = ent_q[ENT_W-1 -: DUR_W];
  assign ent_per = ent_q[PERIOD_W-1:0];

  // Note table: plain register array, writable in any state, never reset.
  always_ff @(posedge clk) begin
    if (cfg_we) mem[cfg_addr] <= cfg_wdata;
  end

  // Fetched entry is pure data; it is always refetched before use.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fetched_q <= 1'b0;
      addr_q    <= '0;
      period_q  <= '0;
      en_q      <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= '0;
      dur_q     <= '0;
    end else begin
      state_q   <= state_d;
      fetched_q <= fetched_d;
      addr_q    <= addr_d;
      period_q  <= period_d;
      en_q      <= en_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      dur_q     <= dur_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ent_d     = ent_q;
    fetched_d = fetched_q;
    addr_d    = addr_q;
    period_d  = period_q;
    en_d      = en_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tick_d    = tick_q;
    dur_d     = dur_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d   = S_LOAD;
          addr_d    = '0;
          busy_d    = 1'b1;
          fetched_d = 1'b0;
        end
      end

      // LOAD takes two cycles: latch the entry, then decode the latched copy.
      S_LOAD: begin
        if (!fetched_q) begin
          ent_d     = mem[addr_q];
          fetched_d = 1'b1;
        end else begin
          fetched_d = 1'b0;
          if (ent_dur == '0) begin
            if (loop_en && (addr_q != '0)) begin
              addr_d = '0;
            end else begin
              // A marker at address 0 ends the tune even when looping,
              // otherwise an empty table would spin forever.
              state_d = S_IDLE;
              done_d  = 1'b1;
              en_d    = 1'b0;
              busy_d  = 1'b0;
            end
          end else begin
            period_d = ent_per;
            en_d     = (ent_per != '0);
            valid_d  = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (tone_ready) begin
          valid_d = 1'b0;
          tick_d  = tempo_div;
          dur_d   = ent_dur;
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (tick_q == '0) begin
          tick_d = tempo_div;
          if (dur_q == DUR_W'(1)) begin
            addr_d = addr_q + ADDR_W'(1);
            if ((addr_q == '1) && !loop_en) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              en_d    = 1'b0;
              busy_d  = 1'b0;
            end else begin
              state_d   = S_LOAD;
              fetched_d = 1'b0;
            end
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end else begin
          tick_d = tick_q - 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything and never produces a done pulse.
    if (stop && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      en_d      = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      fetched_d = 1'b0;
    end
  end

  assign tone_period = period_q;
  assign tone_en     = en_q;
  assign tone_valid  = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cur_addr    = addr_q;

endmodule
